// File: rtl/car_request_sensor.sv
// Cross-street vehicle detector front end: sync, debounce, arrival count,
// level request with grant handshake and a per-second wait timer.
module car_request_sensor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICKS_PER_SEC   = 50000000,
    parameter int unsigned MAX_WAIT_SEC    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_raw,
    input  logic       grant,
    output logic       car,
    output logic       urgent,
    output logic       present,
    output logic [7:0] queue_cnt,
    output logic [7:0] wait_sec
);

    localparam int unsigned DB_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PS_W =
        (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_SERV = 2'd2;

    logic            sync1_q, sync2_q;
    logic            present_q, present_d;
    logic            present_dly_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]      state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [7:0]      wait_q, wait_d;
    logic [7:0]      queue_q, queue_d;
    logic [7:0]      queue_base;
    logic            arrival;
    logic            queue_clr;

    always_comb begin
        present_d = present_q;
        db_cnt_d  = '0;
        if (sync2_q != present_q) begin
            if (db_cnt_q == DB_LAST) begin
                present_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign arrival   = present_q & ~present_dly_q;
    assign queue_clr = (state_q == S_PEND) & grant;

    // Clear first, then fold in a same-cycle arrival.
    always_comb begin
        queue_base = queue_clr ? 8'd0 : queue_q;
        queue_d    = queue_base;
        if (arrival && queue_base != 8'hFF) begin
            queue_d = queue_base + 8'd1;
        end
    end

    // Timer defaults to zero so every entry to or exit from PENDING clears it.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        wait_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (arrival) state_d = S_PEND;
            end
            S_PEND: begin
                if (grant) begin
                    state_d = S_SERV;
                end else if (presc_q == PS_LAST) begin
                    wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                end else begin
                    presc_d = presc_q + PS_W'(1);
                    wait_d  = wait_q;
                end
            end
            S_SERV: begin
                if (!grant) begin
                    state_d = (queue_d != 8'd0) ? S_PEND : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            present_q     <= 1'b0;
            present_dly_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= S_IDLE;
            presc_q       <= '0;
            wait_q        <= 8'd0;
            queue_q       <= 8'd0;
        end else begin
            sync1_q       <= sensor_raw;
            sync2_q       <= sync1_q;
            present_q     <= present_d;
            present_dly_q <= present_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            presc_q       <= presc_d;
            wait_q        <= wait_d;
            queue_q       <= queue_d;
        end
    end

    assign car       = (state_q == S_PEND);
    assign urgent    = car & (32'(wait_q) >= MAX_WAIT_SEC);
    assign present   = present_q;
    assign queue_cnt = queue_q;
    assign wait_sec  = wait_q;

endmodule

// File: tb/tb_car_request_sensor.sv
// Directed bench for car_request_sensor with a fast wait tick.
module tb_car_request_sensor;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_raw;
    logic       grant;
    logic       car;
    logic       urgent;
    logic       present;
    logic [7:0] queue_cnt;
    logic [7:0] wait_sec;

    int checks = 0;
    int errors = 0;

    car_request_sensor #(
        .DEBOUNCE_CYCLES(4),
        .TICKS_PER_SEC  (10),
        .MAX_WAIT_SEC   (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_raw(sensor_raw),
        .grant     (grant),
        .car       (car),
        .urgent    (urgent),
        .present   (present),
        .queue_cnt (queue_cnt),
        .wait_sec  (wait_sec)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        sensor_raw = 1'b0;
        grant      = 1'b0;
        #1;
        check("rst_car", {7'd0, car}, 8'd0);
        check("rst_urgent", {7'd0, urgent}, 8'd0);
        check("rst_present", {7'd0, present}, 8'd0);
        check("rst_queue", queue_cnt, 8'd0);
        check("rst_wait", wait_sec, 8'd0);
        step(2);
        reset = 1'b0;
        step(3);

        // Three-cycle glitch must be rejected.
        sensor_raw = 1'b1;
        step(3);
        sensor_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_present", {7'd0, present}, 8'd0);
        end
        check("glitch_car", {7'd0, car}, 8'd0);
        check("glitch_queue", queue_cnt, 8'd0);

        // Clean arrival latency.
        sensor_raw = 1'b1;
        step(5);
        check("lat_present_e5", {7'd0, present}, 8'd0);
        step(1);
        check("lat_present_e6", {7'd0, present}, 8'd1);
        check("lat_car_e6", {7'd0, car}, 8'd0);
        step(1);
        check("lat_car_e7", {7'd0, car}, 8'd1);
        check("lat_queue", queue_cnt, 8'd1);
        check("lat_wait", wait_sec, 8'd0);
        check("lat_urgent", {7'd0, urgent}, 8'd0);

        // Wait timer, one second per 10 cycles.
        step(9);
        check("wait_e9", wait_sec, 8'd0);
        step(1);
        check("wait_e10", wait_sec, 8'd1);
        step(39);
        check("wait_e49", wait_sec, 8'd4);
        check("urgent_e49", {7'd0, urgent}, 8'd0);
        step(1);
        check("wait_e50", wait_sec, 8'd5);
        check("urgent_e50", {7'd0, urgent}, 8'd1);

        grant = 1'b1;
        step(1);
        check("grant_car", {7'd0, car}, 8'd0);
        check("grant_urgent", {7'd0, urgent}, 8'd0);
        check("grant_wait", wait_sec, 8'd0);
        check("grant_queue", queue_cnt, 8'd0);

        // Two arrivals while serving.
        for (int k = 1; k <= 2; k++) begin
            sensor_raw = 1'b0;
            step(8);
            sensor_raw = 1'b1;
            step(7);
            check("serv_queue", queue_cnt, 8'(k));
            check("serv_car", {7'd0, car}, 8'd0);
        end
        grant = 1'b0;
        step(1);
        check("repend_car", {7'd0, car}, 8'd1);
        check("repend_queue", queue_cnt, 8'd2);
        check("repend_wait", wait_sec, 8'd0);

        // Arrival coincides with grant in PENDING.
        sensor_raw = 1'b0;
        step(8);
        check("pend_hold_car", {7'd0, car}, 8'd1);
        sensor_raw = 1'b1;
        step(6);
        check("coinc_present", {7'd0, present}, 8'd1);
        grant = 1'b1;
        step(1);
        check("coinc_car", {7'd0, car}, 8'd0);
        check("coinc_queue", queue_cnt, 8'd1);
        grant = 1'b0;
        step(1);
        check("coinc_repend", {7'd0, car}, 8'd1);
        check("coinc_queue2", queue_cnt, 8'd1);

        // Async reset mid-PENDING.
        step(30);
        check("pre_rst_wait", wait_sec, 8'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_car", {7'd0, car}, 8'd0);
        check("arst_urgent", {7'd0, urgent}, 8'd0);
        check("arst_present", {7'd0, present}, 8'd0);
        check("arst_queue", queue_cnt, 8'd0);
        check("arst_wait", wait_sec, 8'd0);
        sensor_raw = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        sensor_raw = 1'b1;
        step(5);
        check("rlat_present_e5", {7'd0, present}, 8'd0);
        step(1);
        check("rlat_present_e6", {7'd0, present}, 8'd1);
        check("rlat_car_e6", {7'd0, car}, 8'd0);
        step(1);
        check("rlat_car_e7", {7'd0, car}, 8'd1);
        check("rlat_queue", queue_cnt, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
